// File: rtl/busy_pkg.sv
// Shared definitions for the busy-resource arbiter: counter width and the
// round-robin pick helper used by the top level.
package busy_pkg;

  localparam int unsigned CNT_W     = 16;
  localparam int unsigned MAX_REQ   = 32;
  localparam int unsigned MAX_IDX_W = 5;

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit searched upward from last+1, wrapping modulo nreq.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]   req,
                                       input logic [MAX_IDX_W-1:0] last,
                                       input int unsigned          nreq);
    rr_pick_t    res;
    int unsigned cand;
    res = '0;
    for (int unsigned off = 1; off <= MAX_REQ; off++) begin
      cand = 32'(last) + off;
      if (cand >= nreq) cand = cand - nreq;
      if ((off <= nreq) && !res.valid && req[cand[MAX_IDX_W-1:0]]) begin
        res.valid = 1'b1;
        res.idx   = cand[MAX_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/busy_timer.sv
// Hold-time down-counter for the shared resource: loads on start when idle,
// clears on abort while busy, otherwise counts down to zero.
module busy_timer
  import busy_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_start_amount,
  input  logic             i_abort,
  output logic             o_busy
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_busy;

  // Decrement is gated by cnt != 0, so the counter never wraps.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (r_cnt != '0) begin
      if (i_abort) w_cnt_nxt = '0;
      else         w_cnt_nxt = r_cnt - CNT_W'(1);
    end else if (i_start) begin
      w_cnt_nxt = i_start_amount;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_busy <= (w_cnt_nxt != '0);
    end
  end

  assign o_busy = r_busy;

`ifdef FORMAL
  a_cnt_max:  assert property (@(posedge i_clk) r_cnt <= i_start_amount);
  a_busy_cnt: assert property (@(posedge i_clk) r_busy == (r_cnt != '0));
`endif

endmodule

// File: rtl/busy_arbiter.sv
// Round-robin arbiter sharing one timed busy resource among NREQ requesters;
// issues a one-cycle grant and tracks the owner for the whole hold.
module busy_arbiter
  import busy_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned IDX_W      = 2,
  parameter int unsigned MAX_AMOUNT = 22
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [NREQ-1:0]  i_req,
  input  logic             i_release,
  output logic [NREQ-1:0]  o_grant,
  output logic [IDX_W-1:0] o_owner,
  output logic             o_busy
);

  // Pointer reset to the top index so req[0] is searched first.
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);

  logic [NREQ-1:0]  r_grant;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] r_last;
  logic             w_busy;
  logic             w_start;
  rr_pick_t         w_pick;
  logic [NREQ-1:0]  w_grant_nxt;
  logic [IDX_W-1:0] w_owner_nxt;

  always_comb begin
    w_pick      = rr_pick(MAX_REQ'(i_req), MAX_IDX_W'(r_last), NREQ);
    w_start     = w_pick.valid && !w_busy;
    w_grant_nxt = NREQ'(MAX_REQ'(1) << w_pick.idx);
    w_owner_nxt = IDX_W'(w_pick.idx);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_grant <= '0;
      r_owner <= '0;
      r_last  <= LAST_RST;
    end else begin
      r_grant <= '0;
      if (w_start) begin
        r_grant <= w_grant_nxt;
        r_owner <= w_owner_nxt;
        r_last  <= w_owner_nxt;
      end
    end
  end

  busy_timer u_timer (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_start        (w_start),
    .i_start_amount (CNT_W'(MAX_AMOUNT)),
    .i_abort        (i_release),
    .o_busy         (w_busy)
  );

  assign o_grant = r_grant;
  assign o_owner = r_owner;
  assign o_busy  = w_busy;

`ifdef FORMAL
  a_onehot: assert property (@(posedge i_clk) $onehot0(o_grant));
  a_idle:   assert property (@(posedge i_clk) disable iff (i_reset)
                             (|o_grant) |-> $past(!o_busy));
`endif

endmodule

// File: tb/tb_busy_arbiter.sv
// Bench for busy_arbiter: two instances (hold 22 and hold 1) on shared random
// and directed stimulus, checked against a cycle model plus literal checks.
module tb_busy_arbiter;

  localparam int unsigned NREQ = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       rel;
  logic [3:0] g0, g1;
  logic [1:0] o0, o1;
  logic       b0, b1;

  always #5 clk = ~clk;

  busy_arbiter #(.NREQ(4), .IDX_W(2), .MAX_AMOUNT(22)) u_dut0 (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_release(rel),
    .o_grant(g0), .o_owner(o0), .o_busy(b0));

  busy_arbiter #(.NREQ(4), .IDX_W(2), .MAX_AMOUNT(1)) u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_release(rel),
    .o_grant(g1), .o_owner(o1), .o_busy(b1));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit started = 1'b0;

  int         maxv   [2] = '{22, 1};
  int         m_cnt  [2];
  int         m_last [2];
  int         m_owner[2];
  logic [3:0] m_grant[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: idle-cycle round-robin pick, then hold for maxv cycles or until release.
  always @(posedge clk) begin
    cyc++;
    if (rst) started = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_grant[d] = '0;
      if (rst) begin
        m_cnt[d]   = 0;
        m_owner[d] = 0;
        m_last[d]  = NREQ - 1;
      end else if (m_cnt[d] == 0) begin
        if (req != 4'b0) begin
          int w;
          w = -1;
          for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (m_last[d] + k) % NREQ;
            if (w < 0 && req[c]) w = c;
          end
          m_grant[d]    = 4'(1 << w);
          m_owner[d]    = w;
          m_last[d]     = w;
          m_cnt[d]      = maxv[d];
        end
      end else if (rel) begin
        m_cnt[d] = 0;
      end else begin
        m_cnt[d] = m_cnt[d] - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("d0_grant", 32'(g0), 32'(m_grant[0]));
      check("d0_owner", 32'(o0), 32'(m_owner[0]));
      check("d0_busy",  32'(b0), 32'(m_cnt[0] != 0));
      check("d1_grant", 32'(g1), 32'(m_grant[1]));
      check("d1_owner", 32'(o1), 32'(m_owner[1]));
      check("d1_busy",  32'(b1), 32'(m_cnt[1] != 0));
    end
  end

  task automatic wait_grant0(output int idx, output int at);
    bit found;
    found = 1'b0;
    idx = -1;
    at  = -1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (g0 != 4'b0) begin
        for (int b = 0; b < 4; b++) if (g0[b]) idx = b;
        at    = cyc;
        found = 1'b1;
      end
    end
    if (!found) check("grant_timeout", 32'(0), 32'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    rel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int idx, at, prev, n;
    bit seen, found;
    rst = 1'b1; req = '0; rel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(g0), 32'(0));
    check("rst_busy",  32'(b0), 32'(0));
    check("rst_owner", 32'(o0), 32'(0));
    rst = 1'b0;

    // Single requester: grant next cycle, busy for exactly 22 cycles.
    req = 4'b0001;
    @(negedge clk);
    check("t1_grant", 32'(g0), 32'(4'b0001));
    check("t1_busy",  32'(b0), 32'(1));
    check("t1_owner", 32'(o0), 32'(0));
    req = '0;
    n = 1;
    for (int i = 0; i < 40 && b0; i++) begin
      @(negedge clk);
      if (b0) n++;
    end
    check("t1_busy_len", 32'(n), 32'(22));

    // All requesting: rotation 0,1,2,3,0 at a 23-cycle period.
    do_reset();
    req = 4'b1111;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant0(idx, at);
      check("t2_order", 32'(idx), 32'(k % 4));
      if (k > 0) check("t2_period", 32'(at - prev), 32'(23));
      prev = at;
    end
    req = '0;

    // Early release by owner 2 five cycles after its grant.
    do_reset();
    req = 4'b0100;
    wait_grant0(idx, at);
    check("t3_owner2", 32'(idx), 32'(2));
    req = '0;
    repeat (5) @(negedge clk);
    rel = 1'b1;
    req = 4'b0010;
    @(negedge clk);
    rel = 1'b0;
    check("t3_busy_low", 32'(b0), 32'(0));
    check("t3_no_grant", 32'(g0), 32'(0));
    @(negedge clk);
    check("t3_regrant", 32'(g0), 32'(4'b0010));
    check("t3_owner1",  32'(o0), 32'(1));
    req = '0;

    // Request raised and dropped entirely within the hold is never granted.
    do_reset();
    req = 4'b0001;
    wait_grant0(idx, at);
    req = '0;
    repeat (2) @(negedge clk);
    req = 4'b0010;
    repeat (8) @(negedge clk);
    req = '0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (g0 != 4'b0) seen = 1'b1;
    end
    check("t4_never_granted", 32'(seen), 32'(0));
    check("t4_owner_held",    32'(o0),   32'(0));

    // Reset with cnt=10 restores the pointer to favour req[0] upward.
    do_reset();
    req = 4'b0100;
    wait_grant0(idx, at);
    req = 4'b1010;
    repeat (12) @(negedge clk);
    check("t5_busy_before", 32'(b0), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy_after", 32'(b0), 32'(0));
    check("t5_no_grant",   32'(g0), 32'(0));
    @(negedge clk);
    check("t5_grant_low", 32'(g0), 32'(4'b0010));
    req = '0;

    // Hold of 1 with req 0101: grants alternate 0,2 with period 2.
    do_reset();
    req = 4'b0101;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (g1 != 4'b0) found = 1'b1;
    end
    if (!found) check("t6_timeout", 32'(0), 32'(1));
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        check("t6_grant", 32'(g1), ((i / 2) % 2 == 0) ? 32'(4'b0001) : 32'(4'b0100));
        check("t6_busy",  32'(b1), 32'(1));
      end else begin
        check("t6_grant", 32'(g1), 32'(0));
        check("t6_busy",  32'(b1), 32'(0));
      end
      @(negedge clk);
    end

    // Random traffic with occasional release and reset.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      req = 4'($urandom);
      rel = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    rst = 1'b0; req = '0; rel = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
